router_arbiter: RTL

Round-robin arbiter with burst hold for the multi-input router. It shares the output FIFO between CLIENTS input FIFOs. It takes the router controller's cycle/req and returns a one-hot gnt in the same cycle, which the controller uses directly as its FIFO pop. A client keeps its grant for up to BURST consecutive cycles, then priority rotates.

---
 rtl/router_pkg.sv | 19 +
 rtl/router_rr_pick.sv | 32 +++
 rtl/router_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: width helper, counter width and arbiter state encoding.
package router_pkg;

    localparam int unsigned ROUTER_ARB_CNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Ceiling log2, never less than 1 so single-bit indices stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Rotating priority encoder: first requester found scanning from ptr upward with wrap.
module router_rr_pick
    import router_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter int unsigned ID_W = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    pick,
    output logic [ID_W-1:0] pick_id,
    output logic            any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ID_W'((32'(ptr) + i) % N);
            if (!any && req[idx]) begin
                pick[idx] = 1'b1;
                pick_id   = idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_arbiter.sv
// Round-robin arbiter with burst hold sharing the output FIFO between input FIFOs.
// Optional per-client grant counters enabled by ROUTER_ARB_GNT_COUNT_EN.
module router_arbiter
    import router_pkg::*;
#(
    parameter int unsigned CLIENTS = 2,
    parameter int unsigned BURST   = 4,
    localparam int unsigned ID_W   = clog2(CLIENTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cycle,
    input  logic [CLIENTS-1:0] req,
    output logic [CLIENTS-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
`ifdef ROUTER_ARB_GNT_COUNT_EN
    ,
    output logic [CLIENTS*ROUTER_ARB_CNT_W-1:0] gnt_count
`endif
);

    localparam int unsigned CNT_W = clog2(BURST + 1);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    owner;
    logic [CNT_W-1:0]   burst_cnt;
    arb_state_e         fsm;

    logic [CLIENTS-1:0] pick;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;
    logic               hold;
    logic [ID_W-1:0]    ptr_next;

    router_rr_pick #(
        .N    (CLIENTS),
        .ID_W (ID_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (pick_any)
    );

    // Current owner keeps the grant while it still requests and has burst budget left.
    assign hold     = (fsm == OWNED) && req[owner] && (32'(burst_cnt) < BURST);
    assign ptr_next = ID_W'((32'(pick_id) + 32'd1) % CLIENTS);

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        if (!reset && cycle) begin
            if (hold) begin
                gnt    = CLIENTS'(1) << owner;
                gnt_id = owner;
            end else if (pick_any) begin
                gnt    = pick;
                gnt_id = pick_id;
            end
        end
    end

    assign gnt_valid = |gnt;

    // A stalled output (cycle low) suspends the burst; it only ends if the owner stops requesting.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            fsm       <= IDLE;
        end else if (cycle) begin
            if (hold) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end else if (pick_any) begin
                owner     <= pick_id;
                burst_cnt <= CNT_W'(1);
                ptr       <= ptr_next;
                fsm       <= (BURST > 1) ? OWNED : IDLE;
            end else begin
                fsm <= IDLE;
            end
        end else if (!req[owner]) begin
            fsm <= IDLE;
        end
    end

`ifdef ROUTER_ARB_GNT_COUNT_EN
    logic [ROUTER_ARB_CNT_W-1:0] cnt_q [CLIENTS];

    for (genvar i = 0; i < CLIENTS; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else if (gnt[i] && (cnt_q[i] != '1)) begin
                cnt_q[i] <= cnt_q[i] + ROUTER_ARB_CNT_W'(1);
            end
        end
        assign gnt_count[i*ROUTER_ARB_CNT_W +: ROUTER_ARB_CNT_W] = cnt_q[i];
    end
`endif

endmodule
